tiny_mcu: RTL and testbench

// - Wishbone-programmable array of CORES tiny accumulator cores with a private data RAM each, a write mesh between cores and a shared IO pin block.
// - Host loads per-core instruction memories, pin directions and run mode over Wishbone; cores then move data between pads and RAMs.
// - Top-level user block: sits between the Wishbone slave bus, the logic-analyzer bus and the IO pads.

---
 rtl/tiny_mcu.sv | 231 +++++++++++++++++++++++
 tb/tb_tiny_mcu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_mcu.sv
// tiny_mcu: Wishbone-loaded array of accumulator cores sharing one pin block.
// Define MCU_LA_DEBUG_EN for LA debug probes and LA-driven core soft reset.
module tiny_mcu #(
  parameter int CORES        = 2,
  parameter int LOG_CORES    = 1,
  parameter int MEM_DEPTH    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int PC_WIDTH     = 3,
  parameter int ADDR_WIDTH   = 4,
  parameter int INSTR_WIDTH  = 32,
  parameter int INSTR_DEPTH  = 4,
  parameter int IO_PINS      = 8,
  parameter int IO_PADS      = 38,
  parameter int FIRST_PAD    = 12,
  parameter int LOGIC_PROBES = 128,
  parameter int WB_WIDTH     = 32
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [WB_WIDTH-1:0]     wbs_adr_i,
  input  logic [WB_WIDTH-1:0]     wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [WB_WIDTH-1:0]     wbs_dat_o,
  input  logic [LOGIC_PROBES-1:0] la_data_in,
  input  logic [LOGIC_PROBES-1:0] la_oenb,
  output logic [LOGIC_PROBES-1:0] la_data_out,
  input  logic [IO_PADS-1:0]      io_in,
  output logic [IO_PADS-1:0]      io_out,
  output logic [IO_PADS-1:0]      io_oeb
);

  localparam int IWORDS = 2**PC_WIDTH;
  localparam int KW     = $clog2(DATA_WIDTH);

  localparam logic [ADDR_WIDTH-1:0] A_IN  =
    ADDR_WIDTH'(MEM_DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] A_OUT =
    ADDR_WIDTH'(MEM_DEPTH-2);

  localparam logic [2:0] SRC_RAM = 3'b100;
  localparam logic [2:0] DST_ACC = 3'b100;
  localparam logic [2:0] DST_JMP = 3'b011;
  localparam logic [2:0] DST_MSH = 3'b111;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;

  logic                   r_prog;
  logic [IO_PINS-1:0]     r_dir;
  logic [IO_PINS-1:0]     r_out;
  logic [INSTR_WIDTH-1:0] r_imem [CORES][IWORDS];
  logic [DATA_WIDTH-1:0]  r_ram  [CORES][MEM_DEPTH];
  logic [PC_WIDTH-1:0]    r_pc   [CORES];
  logic [DATA_WIDTH-1:0]  r_acc  [CORES];

  logic                   w_req;
  logic                   w_wr;
  logic                   w_soft;
  logic                   w_run;
  logic [INSTR_WIDTH-1:0] w_ins  [CORES];
  logic [DATA_WIDTH-1:0]  w_opd  [CORES];
  logic [DATA_WIDTH-1:0]  w_res  [CORES];
  logic [ADDR_WIDTH-1:0]  w_wadr [CORES];
  logic [LOG_CORES-1:0]   w_tgt  [CORES];
  logic [CORES-1:0]       w_we;
  logic [DATA_WIDTH-1:0]  w_jin;
  logic                   w_owe;
  logic [DATA_WIDTH-1:0]  w_oval;
  logic [IO_PINS-1:0]     w_onext;
  logic                   w_rsv;
  logic                   w_unused;

  assign w_req     = wbs_cyc_i & wbs_stb_i & ~wb_rst_i;
  assign w_wr      = w_req & wbs_we_i;
  assign wbs_ack_o = w_req;
  assign w_run     = ~r_prog & ~w_soft;

  always_comb begin
    wbs_dat_o = '0;
    case (wbs_adr_i[WB_WIDTH-1 -: 2])
      2'b00: wbs_dat_o = WB_WIDTH'(
        r_imem[wbs_adr_i[PC_WIDTH +: LOG_CORES]]
              [wbs_adr_i[PC_WIDTH-1:0]]);
      2'b01: wbs_dat_o = wbs_adr_i[0] ?
        WB_WIDTH'(r_dir) : WB_WIDTH'(r_prog);
      default: wbs_dat_o = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_prog <= 1'b1;
      r_dir  <= '0;
    end else if (w_wr &&
                 wbs_adr_i[WB_WIDTH-1 -: 2] == 2'b01) begin
      if (wbs_adr_i[0]) r_dir  <= wbs_dat_i[IO_PINS-1:0];
      else              r_prog <= wbs_dat_i[0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_wr && wbs_adr_i[WB_WIDTH-1 -: 2] == 2'b00)
      r_imem[wbs_adr_i[PC_WIDTH +: LOG_CORES]]
            [wbs_adr_i[PC_WIDTH-1:0]] <= wbs_dat_i;
  end

  // Input pins (dir=0) packed LSB-first into the joined input word.
  always_comb begin
    logic [KW-1:0] k;
    w_jin = '0;
    k     = '0;
    for (int i = 0; i < IO_PINS; i++) begin
      if (!r_dir[i]) begin
        w_jin[k] = io_in[FIRST_PAD+i];
        k = k + KW'(1);
      end
    end
  end

  always_comb begin
    w_we  = '0;
    w_rsv = 1'b0;
    for (int c = 0; c < CORES; c++) begin
      w_ins[c]  = r_imem[c][r_pc[c]];
      w_wadr[c] = w_ins[c][4 +: ADDR_WIDTH];
      w_tgt[c]  = LOG_CORES'(c) +
                  w_ins[c][LOG_CORES-1:0];
      w_opd[c]  = DATA_WIDTH'(w_ins[c][15:0]);
      if (w_ins[c][31:29] == SRC_RAM) begin
        if (w_ins[c][ADDR_WIDTH-1:0] == A_IN)
          w_opd[c] = w_jin;
        else
          w_opd[c] = r_ram[c][w_ins[c][ADDR_WIDTH-1:0]];
      end
      case (w_ins[c][22:19])
        ALU_ADD: w_res[c] = r_acc[c] + w_opd[c];
        ALU_SUB: w_res[c] = r_acc[c] - w_opd[c];
        ALU_XOR: w_res[c] = r_acc[c] ^ w_opd[c];
        default: w_res[c] = w_opd[c];
      endcase
      w_we[c] = w_run && (w_ins[c][18:16] == DST_MSH);
      w_rsv   = w_rsv ^ (^w_ins[c][28:23]);
    end
  end

  // Later cores overwrite earlier ones: highest index wins.
  always_comb begin
    w_owe  = 1'b0;
    w_oval = '0;
    for (int c = 0; c < CORES; c++) begin
      if (w_we[c] && w_wadr[c] == A_OUT) begin
        w_owe  = 1'b1;
        w_oval = r_acc[c];
      end
    end
  end

  always_comb begin
    logic [KW-1:0] k;
    w_onext = r_out;
    k       = '0;
    for (int i = 0; i < IO_PINS; i++) begin
      if (r_dir[i]) begin
        w_onext[i] = w_oval[k];
        k = k + KW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)   r_out <= '0;
    else if (w_owe) r_out <= w_onext;
  end

  always_ff @(posedge wb_clk_i) begin
    for (int c = 0; c < CORES; c++) begin
      if (wb_rst_i || !w_run) begin
        r_pc[c]  <= '0;
        r_acc[c] <= '0;
      end else begin
        if (w_ins[c][18:16] == DST_JMP)
          r_pc[c] <= w_ins[c][PC_WIDTH-1:0];
        else
          r_pc[c] <= r_pc[c] + PC_WIDTH'(1);
        if (w_ins[c][18:16] == DST_ACC)
          r_acc[c] <= w_res[c];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int c = 0; c < CORES; c++)
        for (int a = 0; a < MEM_DEPTH; a++)
          r_ram[c][a] <= '0;
    end else begin
      for (int c = 0; c < CORES; c++)
        if (w_we[c])
          r_ram[w_tgt[c]][w_wadr[c]] <= r_acc[c];
    end
  end

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    io_out[FIRST_PAD +: IO_PINS] = r_out;
    io_oeb[FIRST_PAD +: IO_PINS] = ~r_dir;
  end

`ifdef MCU_LA_DEBUG_EN
  assign w_soft = la_data_in[0] & ~la_oenb[0];
  always_comb begin
    la_data_out = '0;
    la_data_out[0] = r_prog;
    la_data_out[1] = ~r_prog;
    la_data_out[2] = w_owe;
    la_data_out[8 +: IO_PINS]  = r_out;
    la_data_out[16 +: IO_PINS] = r_dir;
  end
`else
  assign w_soft      = 1'b0;
  assign la_data_out = '0;
`endif

  assign w_unused = ^{wbs_adr_i, io_in, la_data_in,
                      la_oenb, w_rsv};

endmodule

// File: tb/tb_tiny_mcu.sv
// Self-checking bench for tiny_mcu: Wishbone vector table plus
// directed multi-core programs observed on the pads.
module tb_tiny_mcu;

  logic         clk = 1'b0;
  logic         rst;
  logic         stb, cyc, we;
  logic [31:0]  adr, dat;
  logic         ack;
  logic [31:0]  rdat;
  logic [127:0] la_in, la_oenb, la_out;
  logic [37:0]  io_in, io_out, io_oeb;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  tiny_mcu dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .la_data_in  (la_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_out),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] enc(
    input logic [2:0] s, input logic [3:0] a,
    input logic [2:0] d, input logic [15:0] imm);
    return {s, 6'b0, a, d, imm};
  endfunction

  task automatic wb_xfer(input logic w,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         output logic [31:0] rd,
                         output logic k);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    #1;
    rd = rdat;
    k  = ack;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] a,
                       input logic [31:0] d);
    logic [31:0] rd;
    logic        k;
    wb_xfer(1'b1, a, d, rd, k);
  endtask

  task automatic ld(input int core, input int word,
                    input logic [31:0] ins);
    wb_wr(32'((core << 3) | word), ins);
  endtask

  task automatic wait_out(input string nm,
                          input logic [7:0] mask,
                          input logic [7:0] exp,
                          input int maxcyc);
    for (int i = 0; i < maxcyc; i++) begin
      @(negedge clk);
      if ((io_out[19:12] & mask) == exp) break;
    end
    chk(nm, 64'(io_out[19:12] & mask), 64'(exp));
  endtask

  initial begin
    logic [31:0] rd;
    logic        k;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    adr = '0; dat = '0;
    la_in = '0; la_oenb = '1; io_in = '0;

    tbl[0]  = '{1'b0, 32'h4000_0000, 32'h0, 32'h1, "rd_prog"};
    tbl[1]  = '{1'b0, 32'h4000_0001, 32'h0, 32'h0, "rd_dir"};
    tbl[2]  = '{1'b1, 32'h0000_000D, 32'h1234_5678, 32'h0, "wr_c1w5"};
    tbl[3]  = '{1'b0, 32'h0000_000D, 32'h0, 32'h1234_5678, "rd_c1w5"};
    tbl[4]  = '{1'b1, 32'h0000_0005, 32'hCAFE_F00D, 32'h0, "wr_c0w5"};
    tbl[5]  = '{1'b0, 32'h0000_0005, 32'h0, 32'hCAFE_F00D, "rd_c0w5"};
    tbl[6]  = '{1'b0, 32'h0000_000D, 32'h0, 32'h1234_5678, "rd_c1w5b"};
    tbl[7]  = '{1'b1, 32'h4000_0001, 32'h0000_01A5, 32'h0, "wr_dir"};
    tbl[8]  = '{1'b0, 32'h4000_0001, 32'h0, 32'h0000_00A5, "rd_dir2"};
    tbl[9]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "wr_hole"};
    tbl[10] = '{1'b0, 32'h8000_0000, 32'h0, 32'h0, "rd_hole"};
    tbl[11] = '{1'b0, 32'hC000_0001, 32'h0, 32'h0, "rd_hole2"};
    tbl[12] = '{1'b0, 32'h4000_0000, 32'h0, 32'h1, "rd_prog2"};

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1;
    #1;
    chk("ack_in_rst", 64'(ack), 64'(0));
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("rst_out", 64'(io_out), 64'h0);

    for (int i = 0; i < 13; i++) begin
      wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, rd, k);
      chk({tbl[i].name, "_ack"}, 64'(k), 64'(1));
      if (!tbl[i].we)
        chk(tbl[i].name, 64'(rd), 64'(tbl[i].exp));
    end

    @(negedge clk);
    chk("oeb_a5", 64'(io_oeb[19:12]), 64'h5A);
    chk("oeb_unmgd", 64'({io_oeb[37:20], io_oeb[11:0]}),
        64'h3FFF_FFFF);
    chk("out_idle", 64'(io_out), 64'h0);

    // Pass-through: core0 reads pins 3:0, sends to core1 cell 14.
    wb_wr(32'h4000_0001, 32'hF0);
    ld(0, 0, enc(3'b100, 4'b0011, 3'b100, 16'h000F));
    ld(0, 1, enc(3'b000, 4'b0000, 3'b111, 16'h00E1));
    ld(0, 2, enc(3'b000, 4'b0000, 3'b011, 16'h0000));
    ld(1, 0, enc(3'b000, 4'b0000, 3'b011, 16'h0000));
    io_in[15:12] = 4'b0011;
    wb_wr(32'h4000_0000, 32'h0);
    wait_out("pass_0011", 8'hF0, 8'h30, 10);
    io_in[15:12] = 4'b1001;
    wait_out("pass_1001", 8'hF0, 8'h90, 10);
    io_in[15:12] = 4'b1100;
    wait_out("pass_1100", 8'hF0, 8'hC0, 10);
    chk("oeb_f0", 64'(io_oeb[19:12]), 64'h0F);

    // dir=0x0F: write 5 to cell 14, upper latch bits stay 1100.
    wb_wr(32'h4000_0000, 32'h1);
    wb_wr(32'h4000_0001, 32'h0F);
    ld(0, 0, enc(3'b000, 4'b0011, 3'b100, 16'h0005));
    ld(0, 1, enc(3'b000, 4'b0000, 3'b111, 16'h00E0));
    ld(0, 2, enc(3'b000, 4'b0000, 3'b011, 16'h0002));
    wb_wr(32'h4000_0000, 32'h0);
    wait_out("out_0101", 8'h0F, 8'h05, 10);
    chk("out_keep", 64'(io_out[19:16]), 64'hC);
    chk("oeb_lo", 64'(io_oeb[15:12]), 64'h0);
    chk("oeb_hi", 64'(io_oeb[19:16]), 64'hF);

    // Both cores hit core0 cell 14 in the same cycle.
    wb_wr(32'h4000_0000, 32'h1);
    wb_wr(32'h4000_0001, 32'hFF);
    ld(0, 0, enc(3'b000, 4'b0011, 3'b100, 16'h0005));
    ld(0, 1, enc(3'b000, 4'b0000, 3'b111, 16'h00E0));
    ld(0, 2, enc(3'b100, 4'b0011, 3'b100, 16'h000E));
    ld(0, 3, enc(3'b000, 4'b0000, 3'b100, 16'h0001));
    ld(0, 4, enc(3'b000, 4'b0000, 3'b111, 16'h00E0));
    ld(0, 5, enc(3'b000, 4'b0000, 3'b011, 16'h0005));
    ld(1, 0, enc(3'b000, 4'b0011, 3'b100, 16'h000A));
    ld(1, 1, enc(3'b000, 4'b0000, 3'b111, 16'h00E1));
    ld(1, 2, enc(3'b000, 4'b0000, 3'b011, 16'h0002));
    wb_wr(32'h4000_0000, 32'h0);
    repeat (3) @(negedge clk);
    chk("collide_out", 64'(io_out[19:12]), 64'h0A);
    repeat (8) @(negedge clk);
    chk("collide_ram", 64'(io_out[19:12]), 64'h0B);

    // 0xFFFF + 1 wraps to 0.
    wb_wr(32'h4000_0000, 32'h1);
    ld(1, 0, enc(3'b000, 4'b0000, 3'b011, 16'h0000));
    ld(0, 0, enc(3'b000, 4'b0011, 3'b100, 16'hFFFF));
    ld(0, 1, enc(3'b000, 4'b0000, 3'b100, 16'h0001));
    ld(0, 2, enc(3'b000, 4'b0000, 3'b111, 16'h00E0));
    ld(0, 3, enc(3'b000, 4'b0000, 3'b011, 16'h0003));
    wb_wr(32'h4000_0000, 32'h0);
    wait_out("add_wrap", 8'hFF, 8'h00, 12);

    // 0xF0 ^ 0xFF = 0x0F; 0x0F - 0x10 = 0xFFFF.
    wb_wr(32'h4000_0000, 32'h1);
    ld(0, 0, enc(3'b000, 4'b0011, 3'b100, 16'h00F0));
    ld(0, 1, enc(3'b000, 4'b0010, 3'b100, 16'h00FF));
    ld(0, 2, enc(3'b000, 4'b0001, 3'b100, 16'h0010));
    ld(0, 3, enc(3'b000, 4'b0000, 3'b111, 16'h00E0));
    ld(0, 4, enc(3'b000, 4'b0000, 3'b011, 16'h0004));
    wb_wr(32'h4000_0000, 32'h0);
    wait_out("xor_sub", 8'hFF, 8'hFF, 12);

    // Reset while running.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out", 64'(io_out), 64'h0);
    chk("mid_rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;
    wb_xfer(1'b0, 32'h4000_0000, 32'h0, rd, k);
    chk("mid_rst_prog", 64'(rd), 64'h1);
    wb_xfer(1'b0, 32'h4000_0001, 32'h0, rd, k);
    chk("mid_rst_dir", 64'(rd), 64'h0);

    // RAM cell 14 must read 0 after reset: 0 ^ 0x3C.
    wb_wr(32'h4000_0001, 32'hFF);
    ld(0, 0, enc(3'b100, 4'b0011, 3'b100, 16'h000E));
    ld(0, 1, enc(3'b000, 4'b0010, 3'b100, 16'h003C));
    ld(0, 2, enc(3'b000, 4'b0000, 3'b111, 16'h00E0));
    ld(0, 3, enc(3'b000, 4'b0000, 3'b011, 16'h0003));
    wb_wr(32'h4000_0000, 32'h0);
    wait_out("ram_rst", 8'hFF, 8'h3C, 12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
